alu_result_collector: RTL and testbench
=======================================

Name: alu_result_collector

Overview:
Consumer-side counterpart to the ALU stimulus path. It samples the ALU's registered result/flag pair whenever the producer marks it valid and buffers entries in a small FIFO. It drains the FIFO to a downstream consumer over a valid/ready handshake. It also keeps saturating statistics on the ERR and OVERFLOW flags and flags any lost samples. It sits directly after TOP's o_result/o_flag outputs.

Parameters:
WIDTH, 4, ALU result width in bits; must equal TOP's WIDTH.
DEPTH, 4, FIFO entries; power of two, at least 2.
CNT_WIDTH, 8, width of each statistics counter.

Ports:
i_clk  in  1  clock, rising edge.
i_rstn  in  1  reset, asynchronous, active-low.
i_result  in  WIDTH  ALU result, signed.
i_flag  in  4  ALU flags: bit0 ERR, bit1 NEG, bit2 POS, bit3 OVERFLOW.
i_valid  in  1  i_result/i_flag valid this cycle.
i_clear  in  1  synchronous clear of counters and o_drop.
o_data  out  WIDTH+4  head entry, {flag, result}.
o_valid  out  1  o_data valid (FIFO not empty).
i_ready  in  1  downstream accepts o_data.
o_full  out  1  FIFO holds DEPTH entries.
o_empty  out  1  FIFO holds 0 entries.
o_level  out  clog2(DEPTH)+1  current occupancy.
o_err_cnt  out  CNT_WIDTH  count of sampled entries with ERR set.
o_ovf_cnt  out  CNT_WIDTH  count of sampled entries with OVERFLOW set.
o_drop  out  1  sticky: at least one sample was lost to a full FIFO.

Behaviour:
- One clock; reset is asynchronous and active-low (i_clk, i_rstn).
- Reset values: o_data=0, o_valid=0, o_full=0, o_empty=1, o_level=0, o_err_cnt=0, o_ovf_cnt=0, o_drop=0; pointers=0.
- Reset takes effect immediately on i_rstn falling, mid-operation included. FIFO contents are discarded.
- Push request: i_valid=1 at a rising edge.
- Pop: o_valid && i_ready at a rising edge.
- Push acceptance: a push is accepted if !o_full, or if a pop occurs in the same cycle.
- Full FIFO, push, no pop: the sample is dropped and o_drop is set.
- Empty FIFO, push and i_ready: the push only is performed, since no pop is possible while o_valid=0. There is no bypass.
- Output is first-word-fall-through. o_data always shows the head entry. An entry accepted at edge N is visible on o_data/o_valid after edge N, so latency is 1 cycle.
- o_data is 0 when empty; it is never X.
- Level update: +1 on accepted push without pop, -1 on pop without push, unchanged on simultaneous push and pop.
- o_full and o_empty are derived from the registered level.
- Pointers are log2(DEPTH) bits and wrap naturally modulo DEPTH.
- Counters increment on every i_valid sample whose corresponding flag bit is set, including dropped samples.
- Counters saturate at all-ones and never wrap.
- i_clear=1 zeroes both counters and o_drop. It has priority over any increment or drop in the same cycle.
- i_clear does not affect FIFO contents.
- o_data is passed through unmodified; the block does no sign interpretation.

Decomposition:
- Shared package alu_pkg holds:
  - flag bit positions FLAG_ERR=0, FLAG_NEG=1, FLAG_POS=2, FLAG_OVERFLOW=3;
  - FLAG_W=4;
  - operation codes OP_SUB=2'b00, OP_NAND=2'b01, OP_LEAD1=2'b10, OP_OHDEC=2'b11.
- One natural sub-module, sync_fifo: parameterised width/depth storage, pointers, level and full/empty.
- The counters, drop logic and flag extraction stay in alu_result_collector.

Test Plan:
1. Reset: assert i_rstn=0 for 15 time units -> all outputs at reset values, o_empty=1, o_level=0.
2. Single pass: push result 4'd4 with flag 4'b0100, i_ready=1 -> next cycle o_valid=1, o_data=8'b0100_0100; the entry pops the cycle after and o_empty=1.
3. Overflow: hold i_ready=0, push results 1,2,3,4,5 with flag 0 ->
   - o_full=1 after the 4th push;
   - the 5th sample is dropped and o_drop=1;
   - draining yields 1,2,3,4 in order, then o_empty=1.
4. Full with simultaneous push and pop: fill with 1..4, then push 9 with i_ready=1 -> 1 pops, 9 is accepted, o_level stays 4, o_drop stays 0; drain order is 2,3,4,9.
5. Statistics: push 3 samples with flag 4'b0001 and 2 with 4'b1000 -> o_err_cnt=3, o_ovf_cnt=2.
   - Then pulse i_clear together with an ERR push -> counters read 0.
   - With CNT_WIDTH=2, 5 ERR pushes -> o_err_cnt=3 (saturated).
6. Mid-operation reset: with 2 entries buffered and o_err_cnt=1, drop i_rstn between clock edges -> outputs return to reset values before the next edge.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: flag bit positions, flag width and operation codes.
package alu_pkg;

   // Width of the ALU flag vector and the position of each flag inside it
   localparam int FLAG_W        = 4;
   localparam int FLAG_ERR      = 0;
   localparam int FLAG_NEG      = 1;
   localparam int FLAG_POS      = 2;
   localparam int FLAG_OVERFLOW = 3;

   // ALU operation codes
   typedef enum logic [1:0] {
      OP_SUB   = 2'b00,
      OP_NAND  = 2'b01,
      OP_LEAD1 = 2'b10,
      OP_OHDEC = 2'b11
   } alu_op_e;

endpackage : alu_pkg

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO.
// A push is accepted when the FIFO is not full, or when a pop happens in the
// same cycle. DEPTH must be a power of two so the pointers wrap on their own.
module sync_fifo #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int LVL_W = PTR_W + 1
) (
   input  logic             i_clk,
   input  logic             i_rstn,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty,
   output logic [LVL_W-1:0] o_level
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic             push_ok;
   logic             pop_ok;

   // Decide which operations happen this cycle and compute next pointers/level
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      push_ok  = 1'b0;
      pop_ok   = 1'b0;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;

      pop_ok  = i_pop && (level_q != '0);
      push_ok = i_push && ((level_q != LVL_W'(DEPTH)) || pop_ok);

      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

      case ({push_ok, pop_ok})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase
   end

   // Pointer and occupancy registers
   always_ff @(posedge i_clk or negedge i_rstn) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (!i_rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Entry storage
   always_ff @(posedge i_clk) begin
      // NOTE: storage is not reset; the output mux below hides stale contents while empty.
      if (push_ok) mem_q[wr_ptr_q] <= i_data;
   end

   // Head entry is shown directly; forced to zero while empty so it is never X
   always_comb begin
      o_level = level_q;
      o_full  = (level_q == LVL_W'(DEPTH));
      o_empty = (level_q == '0);
      o_data  = o_empty ? '0 : mem_q[rd_ptr_q];
   end

endmodule : sync_fifo

// File: rtl/alu_result_collector.sv
// Collects ALU {flag, result} samples into a FIFO, drains them over a
// valid/ready handshake and keeps saturating ERR/OVERFLOW statistics plus a
// sticky drop indicator for samples lost to a full FIFO.
module alu_result_collector
   import alu_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int DEPTH     = 4,
   parameter int CNT_WIDTH = 8
) (
   input  logic                      i_clk,
   input  logic                      i_rstn,
   input  logic [WIDTH-1:0]          i_result,
   input  logic [FLAG_W-1:0]         i_flag,
   input  logic                      i_valid,
   input  logic                      i_clear,
   output logic [WIDTH+FLAG_W-1:0]   o_data,
   output logic                      o_valid,
   input  logic                      i_ready,
   output logic                      o_full,
   output logic                      o_empty,
   output logic [$clog2(DEPTH):0]    o_level,
   output logic [CNT_WIDTH-1:0]      o_err_cnt,
   output logic [CNT_WIDTH-1:0]      o_ovf_cnt,
   output logic                      o_drop
);

   logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
   logic [CNT_WIDTH-1:0] ovf_cnt_q, ovf_cnt_d;
   logic                 drop_q, drop_d;
   logic                 pop;
   logic                 drop_hit;
   logic                 err_hit;
   logic                 ovf_hit;

   sync_fifo #(
      .WIDTH (WIDTH + FLAG_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rstn  (i_rstn),
      .i_push  (i_valid),
      .i_pop   (pop),
      .i_data  ({i_flag, i_result}),
      .o_data  (o_data),
      .o_full  (o_full),
      .o_empty (o_empty),
      .o_level (o_level)
   );

   // Handshake, drop detection and saturating counter next-state; clear wins
   always_comb begin
      o_valid  = !o_empty;
      pop      = o_valid && i_ready;
      drop_hit = i_valid && o_full && !pop;
      err_hit  = i_valid && i_flag[FLAG_ERR];
      ovf_hit  = i_valid && i_flag[FLAG_OVERFLOW];

      err_cnt_d = err_cnt_q;
      ovf_cnt_d = ovf_cnt_q;
      drop_d    = drop_q;

      if (i_clear) begin
         err_cnt_d = '0;
         ovf_cnt_d = '0;
         drop_d    = 1'b0;
      end else begin
         if (err_hit && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
         if (ovf_hit && (ovf_cnt_q != '1)) ovf_cnt_d = ovf_cnt_q + CNT_WIDTH'(1);
         if (drop_hit)                     drop_d    = 1'b1;
      end
   end

   // Statistics and drop registers
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         err_cnt_q <= '0;
         ovf_cnt_q <= '0;
         drop_q    <= 1'b0;
      end else begin
         err_cnt_q <= err_cnt_d;
         ovf_cnt_q <= ovf_cnt_d;
         drop_q    <= drop_d;
      end
   end

   // Drive statistic outputs from their registers
   always_comb begin
      o_err_cnt = err_cnt_q;
      o_ovf_cnt = ovf_cnt_q;
      o_drop    = drop_q;
   end

endmodule : alu_result_collector

// File: tb/tb_alu_result_collector.sv
// Directed bench for alu_result_collector. A second instance with 2-bit
// counters shares every input and is used for the saturation check.
module tb_alu_result_collector;

   logic       clk;
   logic       rstn;
   logic [3:0] result;
   logic [3:0] flag;
   logic       valid;
   logic       clear;
   logic       ready;

   logic [7:0] o_data;
   logic       o_valid, o_full, o_empty, o_drop;
   logic [2:0] o_level;
   logic [7:0] o_err_cnt, o_ovf_cnt;

   logic [7:0] s_data;
   logic       s_valid, s_full, s_empty, s_drop;
   logic [2:0] s_level;
   logic [1:0] s_err_cnt, s_ovf_cnt;

   int total = 0;
   int bad   = 0;

   alu_result_collector #(.WIDTH(4), .DEPTH(4), .CNT_WIDTH(8)) dut (
      .i_clk     (clk),
      .i_rstn    (rstn),
      .i_result  (result),
      .i_flag    (flag),
      .i_valid   (valid),
      .i_clear   (clear),
      .o_data    (o_data),
      .o_valid   (o_valid),
      .i_ready   (ready),
      .o_full    (o_full),
      .o_empty   (o_empty),
      .o_level   (o_level),
      .o_err_cnt (o_err_cnt),
      .o_ovf_cnt (o_ovf_cnt),
      .o_drop    (o_drop)
   );

   alu_result_collector #(.WIDTH(4), .DEPTH(4), .CNT_WIDTH(2)) dut_sat (
      .i_clk     (clk),
      .i_rstn    (rstn),
      .i_result  (result),
      .i_flag    (flag),
      .i_valid   (valid),
      .i_clear   (clear),
      .o_data    (s_data),
      .o_valid   (s_valid),
      .i_ready   (ready),
      .o_full    (s_full),
      .o_empty   (s_empty),
      .o_level   (s_level),
      .o_err_cnt (s_err_cnt),
      .o_ovf_cnt (s_ovf_cnt),
      .o_drop    (s_drop)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs change at the falling edge; outputs are checked at the next falling edge
   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic push(input logic [3:0] r, input logic [3:0] f);
      result = r;
      flag   = f;
      valid  = 1'b1;
      cyc();
      valid  = 1'b0;
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_data"},  32'(o_data),    32'h0);
      check({tag, "_valid"}, 32'(o_valid),   32'h0);
      check({tag, "_full"},  32'(o_full),    32'h0);
      check({tag, "_empty"}, 32'(o_empty),   32'h1);
      check({tag, "_level"}, 32'(o_level),   32'h0);
      check({tag, "_err"},   32'(o_err_cnt), 32'h0);
      check({tag, "_ovf"},   32'(o_ovf_cnt), 32'h0);
      check({tag, "_drop"},  32'(o_drop),    32'h0);
   endtask

   initial begin
      rstn = 1'b0; result = '0; flag = '0; valid = 1'b0; clear = 1'b0; ready = 1'b0;

      // 1. Reset
      #12;
      check_reset("rst");
      #3 rstn = 1'b1;
      @(negedge clk);

      // 2. Single pass with 1-cycle latency, then pop
      ready = 1'b1;
      push(4'd4, 4'b0100);
      check("sp_valid", 32'(o_valid), 32'h1);
      check("sp_data",  32'(o_data),  32'h44);
      check("sp_level", 32'(o_level), 32'h1);
      cyc();
      check("sp_empty",   32'(o_empty), 32'h1);
      check("sp_data0",   32'(o_data),  32'h0);
      check("sp_valid0",  32'(o_valid), 32'h0);

      // 3. Overflow with i_ready low
      ready = 1'b0;
      for (int i = 1; i <= 4; i++) push(4'(i), 4'b0000);
      check("ov_full",  32'(o_full),  32'h1);
      check("ov_level", 32'(o_level), 32'h4);
      check("ov_drop0", 32'(o_drop),  32'h0);
      push(4'd5, 4'b0000);
      check("ov_drop1", 32'(o_drop),  32'h1);
      check("ov_lvl5",  32'(o_level), 32'h4);
      ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         check($sformatf("ov_drain%0d", i), 32'(o_data), 32'(i));
         cyc();
      end
      check("ov_empty", 32'(o_empty), 32'h1);

      // 4. Full FIFO with simultaneous push and pop
      ready = 1'b0;
      clear = 1'b1;
      cyc();
      clear = 1'b0;
      check("fp_clr_drop", 32'(o_drop), 32'h0);
      for (int i = 1; i <= 4; i++) push(4'(i), 4'b0000);
      ready = 1'b1;
      push(4'd9, 4'b0000);
      check("fp_level", 32'(o_level), 32'h4);
      check("fp_drop",  32'(o_drop),  32'h0);
      begin
         logic [3:0] exp_order [4];
         exp_order = '{4'd2, 4'd3, 4'd4, 4'd9};
         for (int i = 0; i < 4; i++) begin
            check($sformatf("fp_drain%0d", i), 32'(o_data), 32'(exp_order[i]));
            cyc();
         end
      end
      check("fp_empty", 32'(o_empty), 32'h1);

      // 5. Statistics, clear priority and saturation
      for (int i = 0; i < 3; i++) push(4'(i), 4'b0001);
      for (int i = 0; i < 2; i++) push(4'(i), 4'b1000);
      check("st_err",     32'(o_err_cnt), 32'h3);
      check("st_ovf",     32'(o_ovf_cnt), 32'h2);
      check("st_sat_err", 32'(s_err_cnt), 32'h3);
      clear = 1'b1;
      push(4'd7, 4'b0001);
      clear = 1'b0;
      check("st_clr_err", 32'(o_err_cnt), 32'h0);
      check("st_clr_ovf", 32'(o_ovf_cnt), 32'h0);
      for (int i = 0; i < 5; i++) push(4'(i), 4'b0001);
      check("st_err5",    32'(o_err_cnt), 32'h5);
      check("st_sat5",    32'(s_err_cnt), 32'h3);
      check("st_ovf5",    32'(o_ovf_cnt), 32'h0);

      // 6. Reset between clock edges with data buffered
      valid = 1'b0;
      for (int i = 0; i < 4; i++) cyc();
      clear = 1'b1;
      cyc();
      clear = 1'b0;
      ready = 1'b0;
      push(4'd6, 4'b0001);
      push(4'd3, 4'b0000);
      check("mr_level", 32'(o_level),   32'h2);
      check("mr_err",   32'(o_err_cnt), 32'h1);
      check("mr_head",  32'(o_data),    32'h16);
      #2 rstn = 1'b0;
      #1;
      check_reset("mr");
      @(negedge clk);
      rstn = 1'b1;
      cyc();
      check("mr_post_empty", 32'(o_empty), 32'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_alu_result_collector
